// File: rtl/ksa_16bit_if.sv
// Operand/result bundle for the 16-bit Kogge-Stone adder.
// Operand/result names follow the adder's documented pin names.
interface ksa_16bit_if;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ci;
    logic [15:0] S;
    logic        Co;

    // Driver side: supplies operands, observes the registered result
    modport master (
        output A,
        output B,
        output Ci,
        input  S,
        input  Co
    );

    // Adder side: consumes operands, drives the registered result
    modport slave (
        input  A,
        input  B,
        input  Ci,
        output S,
        output Co
    );
endinterface

// File: rtl/ksa_16bit.sv
// 16-bit radix-2 Kogge-Stone adder with a registered sum and carry-out.
// The prefix tree is 17 positions wide: position 0 holds the carry-in as
// g[-1] (with p[-1]=0), and position k+1 holds operand bit k.
module ksa_16bit (
    input  logic       clk,
    input  logic       rst,
    ksa_16bit_if.slave bus
);

    localparam int unsigned W  = 16;
    localparam int unsigned NP = W + 1;

    // Generate/propagate vector for every prefix position
    typedef struct packed {
        logic [NP-1:0] g;
        logic [NP-1:0] p;
    } gp_t;

    // Black cell: full (G,P) merge of a high group with the adjacent low group
    function automatic logic [1:0] black_cell(input logic gh, input logic ph,
                                              input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

    // Gray cell: group already reaches g[-1], so only G is meaningful
    function automatic logic gray_cell(input logic gh, input logic ph,
                                       input logic gl);
        return gh | (ph & gl);
    endfunction

    // One prefix level with the given span. Positions below the span have no
    // source and pass through; positions whose low source reaches g[-1] use a
    // gray cell and their group P becomes 0 (p[-1]=0 is absorbed into it).
    function automatic gp_t prefix_level(input gp_t lvl_in, input int span);
        gp_t        lvl_out;
        logic [1:0] gp;
        lvl_out = lvl_in;
        for (int k = 0; k < int'(NP); k++) begin
            if (k >= 2 * span) begin
                gp = black_cell(lvl_in.g[k], lvl_in.p[k],
                                lvl_in.g[k-span], lvl_in.p[k-span]);
                lvl_out.g[k] = gp[1];
                lvl_out.p[k] = gp[0];
            end else if (k >= span) begin
                lvl_out.g[k] = gray_cell(lvl_in.g[k], lvl_in.p[k],
                                         lvl_in.g[k-span]);
                lvl_out.p[k] = 1'b0;
            end
        end
        return lvl_out;
    endfunction

    gp_t          lvl0;
    gp_t          lvl1;
    gp_t          lvl2;
    gp_t          lvl3;
    gp_t          lvl4;
    logic [W-1:0] carry;
    logic [W-1:0] s_d;
    logic         co_d;
    logic [W-1:0] s_q;
    logic         co_q;

    // Pre-processing: bitwise generate/propagate with carry-in as g[-1]
    assign lvl0.g = {bus.A & bus.B, bus.Ci};
    assign lvl0.p = {bus.A ^ bus.B, 1'b0};

    // Four prefix levels with spans 1, 2, 4 and 8
    assign lvl1 = prefix_level(lvl0, 1);
    assign lvl2 = prefix_level(lvl1, 2);
    assign lvl3 = prefix_level(lvl2, 4);
    assign lvl4 = prefix_level(lvl3, 8);

    // Carry into bit i is G[i-1:-1], held at prefix position i (c[0] = Ci)
    assign carry = lvl4.g[W-1:0];

    // Next-state sum and carry-out. Position 16 spans bits 15..0 after four
    // levels, so one trailing gray cell folds in g[-1] to form G[15:-1].
    always_comb begin
        s_d  = lvl0.p[NP-1:1] ^ carry;
        co_d = gray_cell(lvl4.g[W], lvl4.p[W], lvl4.g[0]);
    end

    // Result register; synchronous reset wins over a new result
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= W'(0);
            co_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign bus.S  = s_q;
    assign bus.Co = co_q;

endmodule

// File: tb/tb_ksa_16bit.sv
// Scoreboard bench for ksa_16bit: the driver pushes the arithmetic result
// expected one edge later; an independent monitor pops and compares.
module tb_ksa_16bit;

    logic clk;
    logic rst;

    ksa_16bit_if bus ();

    ksa_16bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [16:0] exp;
        string       tag;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       checks   = 0;
    int       failures = 0;
    int       pushed   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned 17-bit addition, or zero under reset
    function automatic logic [16:0] ref_add(input logic r, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        if (r) return 17'h0;
        return {1'b0, a} + {1'b0, b} + {16'h0, c};
    endfunction

    // Present one operand set at the falling edge and queue its expected result
    task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input string tag);
        sb_item_t it;
        @(negedge clk);
        rst    = r;
        bus.A  = a;
        bus.B  = b;
        bus.Ci = c;
        it.exp = ref_add(r, a, b, c);
        it.tag = tag;
        sb_q.push_back(it);
        pushed++;
    endtask

    // Monitor: every rising edge yields exactly one result to compare
    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                checks++;
                if ({bus.Co, bus.S} !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got Co=%b S=%h, expected Co=%b S=%h",
                             it.tag, bus.Co, bus.S, it.exp[16], it.exp[15:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [15:0] corners[$];
        logic [15:0] v;
        int          wait_cycles;

        rst    = 1'b1;
        bus.A  = 16'h0;
        bus.B  = 16'h0;
        bus.Ci = 1'b0;

        // Reset state, with operands that would otherwise produce a carry
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, "reset0");
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "reset1");

        // Directed carry cases, back to back
        drive(1'b0, 16'hFFFF, 16'h0001, 1'b1, "ffff+1+1");
        drive(1'b0, 16'hFFFF, 16'h0019, 1'b1, "ffff+19+1");
        drive(1'b0, 16'h0019, 16'h0019, 1'b0, "19+19");
        drive(1'b0, 16'hFFFF, 16'h0007, 1'b1, "ffff+7+1");
        drive(1'b0, 16'hFFFF, 16'h0001, 1'b0, "full_prop");

        // Reset priority, then first edge after release loads a result
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "rst_prio");
        drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "post_rst");

        // Mid-stream reset discards the in-flight result
        drive(1'b0, 16'h1234, 16'h8765, 1'b1, "pre_mid");
        drive(1'b1, 16'hABCD, 16'h9876, 1'b1, "mid_rst");
        drive(1'b0, 16'h8000, 16'h8000, 1'b0, "after_mid");

        // Corner sweep: zero, all-ones, alternating and single-bit patterns
        corners.push_back(16'h0000);
        corners.push_back(16'hFFFF);
        corners.push_back(16'h5555);
        corners.push_back(16'hAAAA);
        for (int i = 0; i < 16; i++) begin
            v = 16'(1) << i;
            corners.push_back(v);
        end
        foreach (corners[i]) begin
            foreach (corners[j]) begin
                drive(1'b0, corners[i], corners[j], 1'b0, "corner_c0");
                drive(1'b0, corners[i], corners[j], 1'b1, "corner_c1");
            end
        end

        // Random operands every cycle, with occasional reset pulses
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 99) == 0), 16'($urandom), 16'($urandom),
                  1'($urandom), "random");
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, "tail");

        // Drain the scoreboard within a bounded number of cycles
        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (sb_q.size() != 0 || checks != pushed + 1) begin
            failures++;
            $display("FAIL drain: got %0d pending, %0d compared, expected 0 pending, %0d compared",
                     sb_q.size(), checks - 1, pushed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
